// File: rtl/wshbn_uart_if.sv
// Wishbone slave bus bundle for the UART register window.
interface wshbn_uart_if;
    logic [3:0]  ADR_I;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        WE_I;
    logic        STB_I;
    logic        CYC_I;
    logic        ACK_O;

    modport master (
        output ADR_I, DAT_I, WE_I, STB_I, CYC_I,
        input  DAT_O, ACK_O
    );

    modport slave (
        input  ADR_I, DAT_I, WE_I, STB_I, CYC_I,
        output DAT_O, ACK_O
    );
endinterface

// File: rtl/wshbn_uart.sv
// Wishbone UART: TX/RX FIFOs, 8N1 serial engines with programmable divisor,
// level interrupt and status lines.
module wshbn_uart #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] DEF_DIV    = 16'd433
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    wshbn_uart_if.slave wb,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        uart_full,
    output logic        uart_empty,
    output logic        interrupt
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic          ack, rd_pop;
    logic [31:0]   dat;
    logic [15:0]   div;
    logic [1:0]    ctrl;
    logic          overrun, frame_err;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr, tx_rd;
    logic [CW-1:0] tx_cnt;
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wr, rx_rd;
    logic [CW-1:0] rx_cnt;

    state_t        tx_state;
    logic [15:0]   tx_div, tx_tick;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_sh;
    logic          tx_busy;

    state_t        rx_state;
    logic [15:0]   rx_div, rx_tick;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh, rx_byte;
    logic          rx_s1, rx_s2, rx_s3;
    logic          rx_push, rx_ferr;

    logic          req_c, wr_c;
    logic          tx_empty_c, tx_full_c, rx_empty_c, rx_full_c;
    logic          tx_push_ok_c, tx_pop_c, rx_push_ok_c, rx_pop_c;
    logic [15:0]   rx_half_c;
    logic [31:0]   rdata_c;
    logic          unused_bits;

    assign wb.ACK_O    = ack;
    assign wb.DAT_O    = dat;
    assign unused_bits = ^{wb.DAT_I[31:16], wb.ADR_I[1:0]};

    // Handshake decode, FIFO push/pop qualification and read mux
    always_comb begin
        req_c        = wb.CYC_I & wb.STB_I;
        wr_c         = ack & wb.WE_I;
        tx_empty_c   = (tx_cnt == '0);
        tx_full_c    = (tx_cnt == FULL_CNT);
        rx_empty_c   = (rx_cnt == '0);
        rx_full_c    = (rx_cnt == FULL_CNT);
        tx_pop_c     = ~tx_empty_c &
                       ((tx_state == S_IDLE) | ((tx_state == S_STOP) & (tx_tick == tx_div)));
        tx_push_ok_c = wr_c & (wb.ADR_I[3:2] == 2'd0) & (~tx_full_c | tx_pop_c);
        rx_pop_c     = ack & rd_pop;
        rx_push_ok_c = rx_push & (~rx_full_c | rx_pop_c);
        rx_half_c    = 16'((17'(rx_div) + 17'd1) >> 1);
        rdata_c      = '0;
        case (wb.ADR_I[3:2])
            2'd0:    rdata_c = rx_empty_c ? 32'd0 : {24'd0, rx_mem[rx_rd]};
            2'd1:    rdata_c = {25'd0, frame_err, overrun, tx_busy,
                                rx_empty_c, rx_full_c, tx_empty_c, tx_full_c};
            2'd2:    rdata_c = {16'd0, div};
            default: rdata_c = {30'd0, ctrl};
        endcase
    end

    // Read data is captured with the ACK; a DATA read pops only if it returned a byte
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            ack    <= 1'b0;
            dat    <= '0;
            rd_pop <= 1'b0;
        end else begin
            ack    <= req_c & ~ack;
            dat    <= '0;
            rd_pop <= 1'b0;
            if (req_c & ~ack & ~wb.WE_I) begin
                dat    <= rdata_c;
                rd_pop <= (wb.ADR_I[3:2] == 2'd0) & ~rx_empty_c;
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (tx_push_ok_c) tx_mem[tx_wr] <= wb.DAT_I[7:0];
        if (rx_push_ok_c) rx_mem[rx_wr] <= rx_byte;
    end

    // Control registers, FIFO pointers, sticky flags and status outputs
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            div        <= DEF_DIV;
            ctrl       <= '0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            tx_wr      <= '0;
            tx_rd      <= '0;
            tx_cnt     <= '0;
            rx_wr      <= '0;
            rx_rd      <= '0;
            rx_cnt     <= '0;
            uart_full  <= 1'b0;
            uart_empty <= 1'b1;
            interrupt  <= 1'b0;
        end else begin
            if (tx_push_ok_c) tx_wr <= tx_wr + AW'(1);
            if (tx_pop_c)     tx_rd <= tx_rd + AW'(1);
            tx_cnt <= tx_cnt + CW'(tx_push_ok_c) - CW'(tx_pop_c);
            if (rx_push_ok_c) rx_wr <= rx_wr + AW'(1);
            if (rx_pop_c)     rx_rd <= rx_rd + AW'(1);
            rx_cnt <= rx_cnt + CW'(rx_push_ok_c) - CW'(rx_pop_c);

            if (wr_c && wb.ADR_I[3:2] == 2'd2) div  <= wb.DAT_I[15:0];
            if (wr_c && wb.ADR_I[3:2] == 2'd3) ctrl <= wb.DAT_I[1:0];
            if (wr_c && wb.ADR_I[3:2] == 2'd1 && wb.DAT_I[5]) overrun   <= 1'b0;
            if (wr_c && wb.ADR_I[3:2] == 2'd1 && wb.DAT_I[6]) frame_err <= 1'b0;
            if (rx_push & ~rx_push_ok_c) overrun   <= 1'b1;
            if (rx_ferr)                 frame_err <= 1'b1;

            uart_full  <= tx_full_c;
            uart_empty <= rx_empty_c;
            interrupt  <= (ctrl[0] & ~rx_empty_c) | (ctrl[1] & tx_empty_c & ~tx_busy);
        end
    end

    // TX engine: frames follow each other without an idle gap while bytes are queued
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            tx_state <= S_IDLE;
            tx_div   <= '0;
            tx_tick  <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_busy  <= 1'b0;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (tx_pop_c) begin
                        tx_state <= S_START;
                        tx_div   <= div;
                        tx_sh    <= tx_mem[tx_rd];
                        tx_tick  <= '0;
                        tx_busy  <= 1'b1;
                        uart_tx  <= 1'b0;
                    end
                end
                S_START: begin
                    if (tx_tick == tx_div) begin
                        tx_tick  <= '0;
                        tx_bit   <= '0;
                        uart_tx  <= tx_sh[0];
                        tx_state <= S_DATA;
                    end else begin
                        tx_tick <= tx_tick + 16'd1;
                    end
                end
                S_DATA: begin
                    if (tx_tick == tx_div) begin
                        tx_tick <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= S_STOP;
                            uart_tx  <= 1'b1;
                        end else begin
                            tx_bit  <= tx_bit + 3'd1;
                            tx_sh   <= {1'b0, tx_sh[7:1]};
                            uart_tx <= tx_sh[1];
                        end
                    end else begin
                        tx_tick <= tx_tick + 16'd1;
                    end
                end
                S_STOP: begin
                    if (tx_tick == tx_div) begin
                        tx_tick <= '0;
                        if (tx_pop_c) begin
                            tx_state <= S_START;
                            tx_div   <= div;
                            tx_sh    <= tx_mem[tx_rd];
                            uart_tx  <= 1'b0;
                        end else begin
                            tx_state <= S_IDLE;
                            tx_busy  <= 1'b0;
                        end
                    end else begin
                        tx_tick <= tx_tick + 16'd1;
                    end
                end
            endcase
        end
    end

    // RX engine: start bit re-checked at mid-bit, then one sample per bit period
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= S_IDLE;
            rx_div   <= '0;
            rx_tick  <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_byte  <= '0;
            rx_push  <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_s3   <= rx_s2;
            rx_push <= 1'b0;
            rx_ferr <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (rx_s3 & ~rx_s2) begin
                        rx_state <= S_START;
                        rx_div   <= div;
                        rx_tick  <= '0;
                    end
                end
                S_START: begin
                    if (rx_tick == rx_half_c) begin
                        rx_tick  <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        rx_tick <= rx_tick + 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_tick == rx_div) begin
                        rx_tick <= '0;
                        rx_sh   <= {rx_s2, rx_sh[7:1]};
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_tick <= rx_tick + 16'd1;
                    end
                end
                S_STOP: begin
                    if (rx_tick == rx_div) begin
                        rx_tick  <= '0;
                        rx_state <= S_IDLE;
                        if (rx_s2) begin
                            rx_push <= 1'b1;
                            rx_byte <= rx_sh;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        rx_tick <= rx_tick + 16'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wshbn_uart.sv
// Directed self-checking bench for wshbn_uart: registers, TX/RX framing,
// FIFO overflow, error flags, interrupt and mid-frame reset.
module tb_wshbn_uart;
    localparam logic [3:0] A_DATA = 4'h0;
    localparam logic [3:0] A_STAT = 4'h4;
    localparam logic [3:0] A_DIV  = 4'h8;
    localparam logic [3:0] A_CTRL = 4'hC;

    logic clk = 1'b0;
    logic rst_n;
    logic uart_rx, uart_tx, uart_full, uart_empty, interrupt;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic       mon_en = 1'b0;
    logic [7:0] mon_bytes[$];
    logic       mon_stops[$];
    int         mon_gaps[$];
    int         mon_start = 0;

    wshbn_uart_if bus ();

    wshbn_uart #(.FIFO_DEPTH(4), .DEF_DIV(16'd433)) dut (
        .CLK_I(clk), .RST_I(rst_n), .wb(bus),
        .uart_rx(uart_rx), .uart_tx(uart_tx), .uart_full(uart_full),
        .uart_empty(uart_empty), .interrupt(interrupt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wd,
                           output logic [31:0] rd);
        int n;
        @(negedge clk);
        bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = we; bus.ADR_I = adr; bus.DAT_I = wd;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.ACK_O && n < 20);
        if (!bus.ACK_O) check_val("ack_timeout", 32'(bus.ACK_O), 32'd1);
        rd = bus.DAT_O;
        @(posedge clk); #1;
        check_val("ack_pulse", 32'(bus.ACK_O), 32'd0);
        bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.WE_I = 1'b0;
    endtask

    task automatic wb_write(input logic [3:0] adr, input logic [31:0] wd);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, wd, dummy);
    endtask

    task automatic wb_read(input logic [3:0] adr, output logic [31:0] rd);
        wb_xfer(1'b0, adr, 32'd0, rd);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (4) @(negedge clk);
        end
    endtask

    // Serial decoder for DIV=3 (4 clocks per bit); records bytes, stop bits and idle gaps
    initial begin
        int         idle;
        logic [7:0] b;
        idle = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) idle = 0;
            else if (uart_tx == 1'b0) begin
                mon_gaps.push_back(idle);
                mon_start = cyc;
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (4) @(negedge clk);
                mon_stops.push_back(uart_tx);
                mon_bytes.push_back(b);
                @(negedge clk);
                idle = 0;
            end else idle++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [9:0]  fr;
        int          n;
        logic        seen_low;

        rst_n = 1'b0; uart_rx = 1'b1;
        bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.WE_I = 1'b0; bus.ADR_I = '0; bus.DAT_I = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        check_val("rst_ack",   32'(bus.ACK_O), 32'd0);
        check_val("rst_tx",    32'(uart_tx),   32'd1);
        check_val("rst_empty", 32'(uart_empty), 32'd1);
        check_val("rst_full",  32'(uart_full),  32'd0);
        check_val("rst_irq",   32'(interrupt),  32'd0);
        wb_read(A_DIV, rd);  check_val("rst_div", rd, 32'd433);
        wb_read(A_DATA, rd); check_val("rd_empty_rx", rd, 32'd0);
        wb_write(A_DIV, 32'd3);
        wb_read(A_DIV, rd);  check_val("div_rw", rd, 32'd3);

        // Single frame, cycle-exact
        fr = {1'b1, 8'hA5, 1'b0};
        wb_write(A_DATA, 32'hA5);
        @(posedge clk); #1;
        for (int i = 0; i < 40; i++) begin
            check_val("tx_a5_level", 32'(uart_tx), 32'(fr[i / 4]));
            @(posedge clk); #1;
        end
        check_val("tx_idle_after", 32'(uart_tx), 32'd1);
        wb_read(A_STAT, rd); check_val("stat_tx_done", rd, 32'h0A);

        // TX overflow: six writes, the sixth is dropped
        mon_bytes.delete(); mon_stops.delete(); mon_gaps.delete();
        mon_en = 1'b1;
        for (int b = 1; b <= 6; b++) begin
            wb_write(A_DATA, 32'(b));
            if (b == 4) begin
                @(posedge clk); #1;
                check_val("full_after4", 32'(uart_full), 32'd0);
            end
            if (b == 5) begin
                @(posedge clk); #1;
                check_val("full_after5", 32'(uart_full), 32'd1);
            end
        end
        wb_read(A_STAT, rd); check_val("stat_tx_full", rd, 32'h19);
        n = 0;
        while (mon_bytes.size() < 5 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check_val("ovf_frames", 32'(mon_bytes.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check_val("ovf_byte", 32'(mon_bytes[i]), 32'(i + 1));
            check_val("ovf_stop", 32'(mon_stops[i]), 32'd1);
            if (i > 0) check_val("ovf_gap", 32'(mon_gaps[i]), 32'd0);
        end
        repeat (60) @(posedge clk);
        #1;
        check_val("ovf_sixth_dropped", 32'(mon_bytes.size()), 32'd5);
        check_val("ovf_line_idle", 32'(uart_tx), 32'd1);
        mon_en = 1'b0;

        // RX byte and interrupt
        wb_write(A_CTRL, 32'd1);
        wb_read(A_CTRL, rd); check_val("ctrl_rw", rd, 32'd1);
        check_val("irq_before_rx", 32'(interrupt), 32'd0);
        send_rx(8'h3C, 1'b1);
        n = 0;
        while (!interrupt && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("rx_irq", 32'(interrupt), 32'd1);
        check_val("rx_not_empty", 32'(uart_empty), 32'd0);
        wb_read(A_DATA, rd); check_val("rx_data_3c", rd, 32'h3C);
        @(posedge clk); #1;
        check_val("rx_irq_clear", 32'(interrupt), 32'd0);
        check_val("rx_empty_again", 32'(uart_empty), 32'd1);
        wb_write(A_CTRL, 32'hFF);
        wb_read(A_CTRL, rd); check_val("ctrl_mask", rd, 32'd3);
        check_val("tx_irq", 32'(interrupt), 32'd1);
        wb_write(A_CTRL, 32'd0);
        @(posedge clk); #1;
        check_val("irq_off", 32'(interrupt), 32'd0);

        // Framing error: stop bit low
        send_rx(8'h55, 1'b0);
        uart_rx = 1'b1;
        repeat (10) @(posedge clk);
        wb_read(A_STAT, rd); check_val("stat_frame_err", rd, 32'h4A);
        check_val("ferr_rx_empty", 32'(uart_empty), 32'd1);

        // Overrun: five back-to-back frames into a four-entry FIFO
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        send_rx(8'h33, 1'b1);
        send_rx(8'h44, 1'b1);
        send_rx(8'h55, 1'b1);
        repeat (10) @(posedge clk);
        wb_read(A_STAT, rd); check_val("stat_overrun", rd, 32'h66);
        check_val("ovr_not_empty", 32'(uart_empty), 32'd0);
        wb_read(A_DATA, rd); check_val("ovr_rd0", rd, 32'h11);
        wb_read(A_DATA, rd); check_val("ovr_rd1", rd, 32'h22);
        wb_read(A_DATA, rd); check_val("ovr_rd2", rd, 32'h33);
        wb_read(A_DATA, rd); check_val("ovr_rd3", rd, 32'h44);
        wb_read(A_DATA, rd); check_val("ovr_rd_empty", rd, 32'h00);
        wb_write(A_STAT, 32'h60);
        wb_read(A_STAT, rd); check_val("stat_cleared", rd, 32'h0A);

        // Reset during TX bit 3
        mon_gaps.delete(); mon_bytes.delete(); mon_stops.delete();
        mon_en = 1'b1;
        wb_write(A_DATA, 32'hA5);
        wb_write(A_DATA, 32'h0F);
        wb_read(A_STAT, rd); check_val("stat_busy", rd, 32'h18);
        n = 0;
        while (mon_gaps.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("mid_start_seen", 32'(mon_gaps.size()), 32'd1);
        n = 0;
        while (cyc != mon_start + 17 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("mid_bit3_level", 32'(uart_tx), 32'd0);
        rst_n = 1'b0;
        mon_en = 1'b0;
        @(posedge clk); #1;
        check_val("mid_rst_tx", 32'(uart_tx), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        check_val("mid_rst_empty", 32'(uart_empty), 32'd1);
        check_val("mid_rst_full",  32'(uart_full),  32'd0);
        wb_read(A_STAT, rd); check_val("mid_rst_stat", rd, 32'h0A);
        wb_read(A_DIV, rd);  check_val("mid_rst_div", rd, 32'd433);
        seen_low = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (uart_tx == 1'b0) seen_low = 1'b1;
        end
        check_val("mid_rst_no_start", 32'(seen_low), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wshbn_uart.md
# wshbn_uart

Wishbone slave UART occupying bus window ADR[7:4] = 4'b0010 of the RISC-V SoC bus, alongside the PIO (0x0X) and timer (0x1X) slaves. The CPU reaches it through the wishbone master: it writes bytes into a TX FIFO and reads bytes from an RX FIFO. The 8N1 serial engines run at a programmable baud divisor. The block provides a level interrupt for the interrupt controller and status lines for board LEDs.

## Interface
- FIFO_DEPTH, 4: entries per TX and RX FIFO; must be a power of 2, ≥2.
- DEF_DIV, 16'd433: reset value of the baud divisor. Bit period = DIV+1 clocks.
- CLK_I  in  1  system clock; the only clock in the block.
- RST_I  in  1  reset, synchronous, active-low.
- ADR_I  in  4  byte address; ADR_I[3:2] selects the register, ADR_I[1:0] is ignored.
- DAT_I  in  32  write data; only [15:0] is used.
- DAT_O  out  32  read data; valid while ACK_O=1, 0 otherwise.
- WE_I  in  1  1 = write.
- STB_I  in  1  strobe, already decoded with CYC and the address window.
- CYC_I  in  1  bus cycle.
- ACK_O  out  1  single-cycle acknowledge.
- uart_rx  in  1  serial input, asynchronous.
- uart_tx  out  1  serial output; idle level is 1.
- uart_full  out  1  TX FIFO full.
- uart_empty  out  1  RX FIFO empty.
- interrupt  out  1  level interrupt request.

## Operation
Register map, selected by ADR_I[3:2]:
- 0 DATA:
  - Write: pushes DAT_I[7:0] to the TX FIFO. If the TX FIFO is full, the byte is silently dropped.
  - Read: pops the RX FIFO and returns {24'b0, byte}. If the RX FIFO is empty, returns 0 and does not pop.
- 1 STATUS (read): bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 tx_busy, bit5 overrun, bit6 frame_err, other bits 0.
  - Write: writing 1 to bit5 or bit6 clears that sticky flag. Other bits are ignored.
- 2 DIV: 16-bit baud divisor, read/write.
- 3 CTRL: bit0 rx_irq_en, bit1 tx_irq_en, read/write. Other bits read 0.
- interrupt = (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty & !tx_busy).

TX FSM:
- IDLE → START when the TX FIFO is non-empty. In this transition: pop one byte, latch DIV, set tx_busy.
- START: drive 0 for one bit period, then go to DATA.
- DATA: send 8 bits, LSB first, one bit period each, then go to STOP.
- STOP: drive 1 for one bit period.
- Leaving STOP: go to START if the FIFO is non-empty (back-to-back frames, no idle gap); otherwise go to IDLE and clear tx_busy.

RX FSM:
- uart_rx passes through a 2-flop synchronizer.
- IDLE → START on a synchronized 1→0 transition.
- START: at count (DIV+1)/2 (integer division), sample the line. If it is still 0, go to DATA; otherwise it was a glitch and the FSM returns to IDLE.
- DATA: sample 8 bits, one full bit period apart, LSB first.
- STOP: sample once.
  - Stop bit = 1: push the byte. If the RX FIFO is full, drop the byte and set overrun.
  - Stop bit = 0: set frame_err and discard the byte.
  - In both cases return to IDLE right after the stop-bit sample. The next start edge is accepted immediately.
- Each FSM latches DIV at frame start. A DIV write during a frame takes effect at the next frame.

Reset values (RST_I=0 sampled on a CLK_I edge):
- ACK_O=0, DAT_O=0, uart_tx=1, uart_full=0, uart_empty=1, interrupt=0.
- DIV=DEF_DIV, CTRL=0, both FIFOs empty, both FSMs in IDLE, sticky flags 0.
- A reset mid-frame aborts the frame. uart_tx=1 from the first clock after the reset edge.

## Timing
- ACK_O rises the cycle after a clock edge samples CYC_I&STB_I=1 with ACK_O=0. It stays high for exactly 1 cycle.
- A transfer held continuously gets an ACK every 2nd cycle.
- All register side effects (push, pop, flag clear, DIV/CTRL update) occur on the edge that ends the ACK cycle: exactly once per ACK.
- DAT_O for a DATA read shows the FIFO head during the ACK cycle.
- TX latency: a DATA write acknowledged in cycle n gives uart_tx=0 in cycle n+2 when the TX FSM is idle.
- FIFO pointers wrap modulo FIFO_DEPTH. Occupancy counters are log2(FIFO_DEPTH)+1 bits wide.
- Simultaneous push and pop on the same FIFO:
  - Full FIFO: the pop happens first, then the push is accepted.
  - Empty FIFO: the push is accepted; the pop returns 0 and does not remove anything.
- uart_full, uart_empty and interrupt are registered and update the cycle after the FIFO change.

## Test plan
- Reset output values: hold RST_I=0 for 2 clocks, then release → ACK_O=0, uart_tx=1, uart_empty=1, uart_full=0, interrupt=0. Reading DIV returns 433.
- TX frame: write DIV=3, then DATA=0x A5 → starting 2 cycles after the ACK, uart_tx shows 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks. tx_busy clears after 40 clocks.
- TX overflow: with DIV=3, write 6 bytes 0x01–0x06 back-to-back (FIFO_DEPTH=4) → the first byte is popped into the TX FSM before the fifth write and sent as the first frame. uart_full=1 after the fifth write. The sixth byte is dropped. The serial output carries 0x01–0x05 with no idle gap between frames.
- RX and interrupt: set CTRL=1, drive the 0x3C frame on uart_rx at 4 clocks per bit → interrupt=1 after the stop-bit sample. Reading DATA returns 0x3C. interrupt=0 and uart_empty=1 afterwards.
- Framing error and overrun: send 0x55 with the stop bit at 0 → frame_err=1 and the RX FIFO stays empty. Send 5 valid bytes without reading → overrun=1 and a read returns the first 4 bytes in order. Writing 0x60 to STATUS → both flags read 0.
- Reset mid-frame: assert RST_I during TX bit 3 → uart_tx=1 on the next clock, the FIFOs are empty, and no further start bit appears.
